// File: rtl/ste_sndfifo.sv
// DMA sound playback stage: buffers MCU sound words in a small FIFO and releases
// signed 8-bit stereo/mono samples at the programmed rate, requesting refills via sreq.
module ste_sndfifo #(
  parameter int DEPTH = 4
) (
  input  logic               clk32,
  input  logic               resb,
  input  logic               mhz8_en1,
  input  logic               sndon,
  input  logic               sload_n,
  input  logic [15:0]        din,
  input  logic               mode_we,
  input  logic [7:0]         mode_din,
  output logic [7:0]         mode_dout,
  output logic               sreq,
  output logic signed [7:0]  sample_l,
  output logic signed [7:0]  sample_r,
  output logic               sample_stb,
  output logic               underrun,
  output logic               overflow
);

  localparam int DATA_W = 16;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int PW     = 11;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [PW-1:0]     presc;
  logic              sload_prev_p0;
  logic              mono;
  logic              byte_sel;
  logic [1:0]        rate;

  logic              load_edge;
  logic              load_ok;
  logic              load_ovf;
  logic              fifo_empty;
  logic              fifo_full;
  logic              tick;
  logic              pop;
  logic [DATA_W-1:0] head;

  function automatic logic [PW-1:0] period_last(input logic [1:0] r);
    return (PW'(1280) >> r) - PW'(1);
  endfunction

  function automatic logic signed [7:0] to_sample(input logic [7:0] b);
    return $signed(b);
  endfunction

  assign mode_dout  = {mono, 5'b00000, rate};

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(DEPTH));
  assign head       = mem[rd_ptr];

  // load detect: previous-high / now-low on the raw strobe
  assign load_edge  = sload_prev_p0 & ~sload_n;
  assign load_ok    = sndon & load_edge & ~fifo_full;
  assign load_ovf   = sndon & load_edge & fifo_full;

  // rate tick and pop decision; a mono high-byte tick leaves the word in place
  assign tick       = sndon & mhz8_en1 & (presc == period_last(rate));
  assign pop        = tick & ~fifo_empty & (~mono | byte_sel);

  always_ff @(posedge clk32) begin
    if (load_ok)
      mem[wr_ptr] <= din;
  end

  // state update and registered outputs
  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      sload_prev_p0 <= 1'b1;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      presc         <= '0;
      mono          <= 1'b0;
      rate          <= 2'b00;
      byte_sel      <= 1'b0;
      sreq          <= 1'b0;
      sample_l      <= '0;
      sample_r      <= '0;
      sample_stb    <= 1'b0;
      underrun      <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      sload_prev_p0 <= sload_n;
      sample_stb    <= 1'b0;
      underrun      <= 1'b0;
      overflow      <= load_ovf;

      if (!sndon) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        presc    <= '0;
        byte_sel <= 1'b0;
        sreq     <= 1'b0;
        sample_l <= '0;
        sample_r <= '0;
      end else begin
        sreq <= (count <= CW'(DEPTH - 2));

        if (tick)
          presc <= '0;
        else if (mhz8_en1)
          presc <= presc + PW'(1);

        if (load_ok)
          wr_ptr <= wr_ptr + AW'(1);
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(load_ok) - CW'(pop);

        if (tick) begin
          if (fifo_empty) begin
            underrun <= 1'b1;
          end else begin
            sample_stb <= 1'b1;
            if (!mono) begin
              sample_l <= to_sample(head[15:8]);
              sample_r <= to_sample(head[7:0]);
            end else if (!byte_sel) begin
              sample_l <= to_sample(head[15:8]);
              sample_r <= to_sample(head[15:8]);
              byte_sel <= 1'b1;
            end else begin
              sample_l <= to_sample(head[7:0]);
              sample_r <= to_sample(head[7:0]);
              byte_sel <= 1'b0;
            end
          end
        end
      end

      // mode write overrides the prescaler and byte phase updated above
      if (mode_we) begin
        mono <= mode_din[7];
        rate <= mode_din[1:0];
        if (mode_din[1:0] != rate)
          presc <= '0;
        if (!mode_din[7])
          byte_sel <= 1'b0;
      end
    end
  end

endmodule
